// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
// Shares one pipelined signed 16x16 multiplier core between two requesters.
// A request is accepted in IDLE, the operands are presented to the core with a
// one-cycle start pulse, the block waits for the core's done and then returns
// the 32-bit product on the granted port's response channel. Only one
// operation is outstanding at a time.
//
// Parameters:
//   FAIR    : 1 = round-robin between ports, 0 = fixed priority (port 0 wins)
//   TIMEOUT : watchdog limit in WAIT cycles (2..255), watchdog build only
//
// Optional feature (compile-time macro MULT_ARB_WATCHDOG_EN):
//   defined   : WAIT is bounded by TIMEOUT cycles; on expiry an error response
//               (rsp_data=0, rsp_err=1) is returned instead of a product.
//   undefined : no watchdog, rsp_err is constant 0, WAIT lasts until m_done.
//
// Ports:
//   clk, resetq            clock (rising edge), async active-high reset
//   req_valid/req_ready    per-port request handshake (req_ready combinational)
//   req_a0/req_b0          port 0 signed operands
//   req_a1/req_b1          port 1 signed operands
//   rsp_valid/rsp_ready    per-port response handshake (at most one valid)
//   rsp_data, rsp_err      shared response payload and watchdog-abort flag
//   m_start, m_md, m_mr    start pulse and operands to the multiplier core
//   m_product, m_done      product and completion pulse from the core
//   busy                   high in every state except IDLE
//   grant_id               port currently or most recently granted
// -----------------------------------------------------------------------------
module mult_arbiter #(
    parameter int unsigned FAIR    = 1,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_a0,
    input  logic [15:0] req_b0,
    input  logic [15:0] req_a1,
    input  logic [15:0] req_b1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        m_start,
    output logic [15:0] m_md,
    output logic [15:0] m_mr,
    input  logic [31:0] m_product,
    input  logic        m_done,
    output logic        busy,
    output logic        grant_id
);

    localparam int unsigned OP_W   = 16;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned WD_W   = 8;
    localparam logic [WD_W-1:0] LP_TIMEOUT = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [OP_W-1:0]     r_md;
    logic [OP_W-1:0]     r_mr;
    logic [PROD_W-1:0]   r_rsp_data;
    logic                r_grant;
    logic                r_last;

    logic                w_any;
    logic                w_sel;
    logic                w_accept;
    logic                w_take;
    logic                w_abort;
    logic                w_release;
    logic                w_wd_hit;

    // Port selection; the last-grant pointer resets to 1 so port 0 wins the
    // first contention under round-robin.
    assign w_any = |req_valid;

    always_comb begin : p_select
        w_sel = 1'b0;
        case (req_valid)
            2'b01:   w_sel = 1'b0;
            2'b10:   w_sel = 1'b1;
            2'b11:   w_sel = (FAIR != 0) ? ~r_last : 1'b0;
            default: w_sel = 1'b0;
        endcase
    end

`ifdef MULT_ARB_WATCHDOG_EN
    logic [WD_W-1:0]     r_wd_cnt;
    logic                r_rsp_err;

    // Counts WAIT cycles; sits at zero outside WAIT so it is clear on entry.
    always_ff @(posedge clk or posedge resetq) begin : p_wd_cnt
        if (resetq) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end else begin
            r_wd_cnt <= '0;
        end
    end

    // Limit reached during the TIMEOUT-th WAIT cycle; m_done takes precedence
    // in the FSM when both happen together.
    assign w_wd_hit = (r_state == S_WAIT) && (r_wd_cnt == (LP_TIMEOUT - WD_W'(1)));

    always_ff @(posedge clk or posedge resetq) begin : p_rsp_err
        if (resetq) begin
            r_rsp_err <= 1'b0;
        end else if (w_take) begin
            r_rsp_err <= 1'b0;
        end else if (w_abort) begin
            r_rsp_err <= 1'b1;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    logic                w_unused_timeout;

    assign w_wd_hit         = 1'b0;
    assign rsp_err          = 1'b0;
    assign w_unused_timeout = ^LP_TIMEOUT;
`endif

    // State register.
    always_ff @(posedge clk or posedge resetq) begin : p_state
        if (resetq) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin : p_fsm
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_take       = 1'b0;
        w_abort      = 1'b0;
        w_release    = 1'b0;
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;
        m_start      = 1'b0;
        busy         = 1'b1;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                // The selected port always has its valid set, so ready on it
                // is an accept.
                if (w_any) begin
                    req_ready[w_sel] = 1'b1;
                    w_accept         = 1'b1;
                    w_next_state     = S_START;
                end
            end
            S_START: begin
                m_start      = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (m_done) begin
                    w_take       = 1'b1;
                    w_next_state = S_RESP;
                end else if (w_wd_hit) begin
                    w_abort      = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[r_grant] = 1'b1;
                if (rsp_ready[r_grant]) begin
                    w_release    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture, grant tracking and response payload.
    always_ff @(posedge clk or posedge resetq) begin : p_data
        if (resetq) begin
            r_md       <= '0;
            r_mr       <= '0;
            r_grant    <= 1'b0;
            r_last     <= 1'b1;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_md    <= w_sel ? req_a1 : req_a0;
                r_mr    <= w_sel ? req_b1 : req_b0;
                r_grant <= w_sel;
            end
            if (w_take) begin
                r_rsp_data <= m_product;
            end else if (w_abort) begin
                r_rsp_data <= '0;
            end
            if (w_release) begin
                r_last <= r_grant;
            end
        end
    end

    assign m_md     = r_md;
    assign m_mr     = r_mr;
    assign rsp_data = r_rsp_data;
    assign grant_id = r_grant;

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Shares one pipelined signed 16x16 multiplier core between two requesters, for example the J1 I/O port and a hardware control loop. Each requester has a valid/ready request channel and a valid/ready response channel. The block arbitrates between them, issues a one-cycle start pulse to the core, waits for the core's done, and returns the 32-bit product to the granted requester. Only one operation is outstanding at a time.

Parameters:
FAIR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.
TIMEOUT, 64, watchdog limit in cycles spent in WAIT (used only with MULT_ARB_WATCHDOG_EN); legal range 2..255.

Ports:
clk  input  1  system clock, rising edge
resetq  input  1  reset, asynchronous, active-high
req_valid  input  2  per-port request valid
req_ready  output  2  per-port request accept
req_a0  input  16  port 0 multiplicand, signed
req_b0  input  16  port 0 multiplier, signed
req_a1  input  16  port 1 multiplicand, signed
req_b1  input  16  port 1 multiplier, signed
rsp_valid  output  2  per-port response valid; at most one bit set
rsp_ready  input  2  per-port response accept
rsp_data  output  32  signed product, shared by both ports
rsp_err  output  1  response is a watchdog abort; qualified by rsp_valid
m_start  output  1  one-cycle start pulse to the multiplier core
m_md  output  16  operand A to the core
m_mr  output  16  operand B to the core
m_product  input  32  core product
m_done  input  1  core completion pulse
busy  output  1  high in every state except IDLE
grant_id  output  1  port currently or most recently granted

Behaviour:
- States: IDLE, START, WAIT, RESP; all state registers are reset asynchronously.
- Reset values:
  - State is IDLE.
  - req_ready, rsp_valid, m_start, rsp_err, busy are 0.
  - rsp_data, m_md, m_mr are 0.
  - grant_id is 0; the internal last-grant pointer is 1, so port 0 wins the first contention.
- IDLE, selection:
  - If only one req_valid bit is set, that port is selected.
  - If both are set and FAIR=1, the port other than last-grant is selected.
  - If both are set and FAIR=0, port 0 is selected.
- IDLE, accept:
  - req_ready is combinational: it is 1 only for the selected port and only in IDLE.
  - A transfer occurs when req_valid&req_ready. On that edge: latch the port's A/B into m_md/m_mr, set grant_id, go to START.
- START: m_start=1 for exactly one cycle, then go to WAIT. m_md/m_mr hold stable from START until the block returns to IDLE.
- WAIT:
  - m_done is sampled only in this state; m_done in any other state is ignored.
  - On m_done: rsp_data<=m_product, rsp_err<=0, go to RESP.
- RESP:
  - rsp_valid[grant_id]=1; rsp_data and rsp_err are held stable.
  - On rsp_ready[grant_id]: clear rsp_valid, update last-grant to grant_id, go to IDLE.
  - rsp_ready on the non-granted port is ignored.
- Latency, for a core with done L cycles after start:
  - Accept at edge T; m_start high during cycle T+1; rsp_valid high from T+L+2.
  - Back-to-back throughput is one result per L+3 cycles, given immediate rsp_ready.
- Requests arriving while busy wait; req_ready stays 0 until IDLE. A requester must hold req_valid and its operands until accepted.
- Reset asserted mid-operation:
  - Abort immediately to IDLE with all outputs at reset values.
  - The pending response is discarded.
  - A later stale m_done is ignored because the block is not in WAIT.
- Arithmetic is performed by the core (signed two's-complement); the block does no width conversion and passes m_product through unmodified.

Optional Feature:
Macro MULT_ARB_WATCHDOG_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no m_done, go to RESP with rsp_data=0 and rsp_err=1.
  - If m_done arrives in the same cycle the limit is reached, m_done wins: normal response, rsp_err=0.
- Undefined: no counter exists, rsp_err is tied 0, and WAIT lasts indefinitely.

Test Plan:
- Port 0 requests 0x7FFF*0x7FFF, core model L=17: m_start one cycle after accept; rsp_valid[0] 19 cycles after accept with rsp_data=0x3FFF0001 and rsp_err=0.
- Port 1 requests 0xFFFE*0x0003 (-2*3): rsp_data=0xFFFFFFFA on rsp_valid[1]; rsp_valid[0] stays 0 throughout.
- Both ports request continuously with FAIR=1: grants alternate 0,1,0,1 starting with 0. Rerun with FAIR=0: port 0 is granted every time, port 1 never.
- Response backpressure: rsp_ready[0] held low 10 cycles. rsp_valid and rsp_data=0x40000000 (0x8000*0x8000) are held stable, req_ready stays 0, no m_start is issued.
- Reset pulsed during WAIT, then m_done asserted: all outputs return to 0, no response is issued, and the next request completes normally.
- MULT_ARB_WATCHDOG_EN defined, TIMEOUT=8, core never asserts done: response after 8 WAIT cycles with rsp_data=0 and rsp_err=1; the block then returns to IDLE.
